// File: rtl/hdmi_pkt_sched.sv
// HDMI data-island scheduler: SLOTS packet loads per line at T+2 + k*SLOT_CYCLES; free-running, no backpressure.
// Audio sample packets are scheduled only when HDMI_PKT_SCHED_AUDIO_EN is defined.
module hdmi_pkt_sched #(
  parameter int LINE_PERIOD = 45,
  parameter int SLOTS       = 3,
  parameter int SLOT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_strobe,
  input  logic       vsync,
  input  logic       aud_avail,
  output logic       aud_pop,
  output logic       pkt_load,
  output logic [2:0] pkt_sel,
  output logic       busy,
  output logic       overrun
);

`ifdef HDMI_PKT_SCHED_AUDIO_EN
  localparam bit AUD_EN = 1'b1;
`else
  localparam bit AUD_EN = 1'b0;
`endif

  localparam int CW  = (LINE_PERIOD > 1) ? $clog2(LINE_PERIOD) : 1;
  localparam int SW  = $clog2(SLOTS + 1);
  localparam int CYW = $clog2(SLOT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_LOAD, S_SLOT} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_line_cnt;
  logic [SW-1:0]  r_slot;
  logic [CYW-1:0] r_cyc;
  logic [1:0]     r_aud_cnt;
  logic [2:0]     r_pkt_sel, w_sel;
  logic           r_acr_pend, r_avi_pend, r_aif_pend;
  logic           r_vsync_d, r_overrun;
  logic           w_start, w_last_slot, w_cyc_end, w_grant, w_aud_ok, w_vs_rise;

  assign w_start     = line_strobe && (r_state == S_IDLE);
  assign w_last_slot = (r_slot == SW'(SLOTS - 1));
  // The ARB cycle of the next slot is counted inside the current slot period.
  assign w_cyc_end   = (r_cyc == (w_last_slot ? CYW'(SLOT_CYCLES - 2) : CYW'(SLOT_CYCLES - 3)));
  assign w_grant     = (r_state == S_ARB);
  assign w_aud_ok    = AUD_EN && aud_avail && (r_aud_cnt < 2'd2);
  assign w_vs_rise   = vsync && !r_vsync_d;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (line_strobe) w_next = S_ARB;
      S_ARB:   w_next = S_LOAD;
      S_LOAD:  w_next = S_SLOT;
      S_SLOT:  if (w_cyc_end) w_next = w_last_slot ? S_IDLE : S_ARB;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel = 3'd0;
    if (r_acr_pend)      w_sel = 3'd2;
    else if (w_aud_ok)   w_sel = 3'd1;
    else if (r_avi_pend) w_sel = 3'd3;
    else if (r_aif_pend) w_sel = 3'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_line_cnt <= '0;
      r_slot     <= '0;
      r_cyc      <= '0;
      r_aud_cnt  <= '0;
      r_pkt_sel  <= '0;
      r_acr_pend <= 1'b0;
      r_avi_pend <= 1'b0;
      r_aif_pend <= 1'b0;
      r_vsync_d  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_vsync_d <= vsync;

      if (line_strobe)
        r_line_cnt <= (r_line_cnt == CW'(LINE_PERIOD - 1)) ? '0 : r_line_cnt + CW'(1);
      if (line_strobe && (r_state != S_IDLE))
        r_overrun <= 1'b1;

      // Set takes precedence over a same-cycle grant clear.
      if (line_strobe && (r_line_cnt == '0)) r_acr_pend <= 1'b1;
      else if (w_grant && (w_sel == 3'd2))   r_acr_pend <= 1'b0;
      if (w_vs_rise)                         r_avi_pend <= 1'b1;
      else if (w_grant && (w_sel == 3'd3))   r_avi_pend <= 1'b0;
      if (w_vs_rise)                         r_aif_pend <= 1'b1;
      else if (w_grant && (w_sel == 3'd4))   r_aif_pend <= 1'b0;

      if (w_grant) r_pkt_sel <= w_sel;

      if (w_start)                           r_aud_cnt <= '0;
      else if (w_grant && (w_sel == 3'd1))   r_aud_cnt <= r_aud_cnt + 2'd1;

      if (w_start)
        r_slot <= '0;
      else if ((r_state == S_SLOT) && w_cyc_end && !w_last_slot)
        r_slot <= r_slot + SW'(1);

      if (r_state == S_LOAD)      r_cyc <= '0;
      else if (r_state == S_SLOT) r_cyc <= r_cyc + CYW'(1);
    end
  end

  assign pkt_load = (r_state == S_LOAD);
  assign pkt_sel  = r_pkt_sel;
  assign aud_pop  = AUD_EN && pkt_load && (r_pkt_sel == 3'd1);
  assign busy     = (r_state != S_IDLE);
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_hdmi_pkt_sched.sv
// Scoreboard bench for hdmi_pkt_sched: expected packet selections and load cycles queued per strobe.
module tb_hdmi_pkt_sched;

`ifdef HDMI_PKT_SCHED_AUDIO_EN
  localparam bit AUD = 1'b1;
`else
  localparam bit AUD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_strobe = 1'b0;
  logic       vsync = 1'b0;
  logic       aud_avail = 1'b0;
  logic       aud_pop, pkt_load, busy, overrun;
  logic [2:0] pkt_sel;

  hdmi_pkt_sched dut (
    .clk(clk), .rst(rst), .line_strobe(line_strobe), .vsync(vsync),
    .aud_avail(aud_avail), .aud_pop(aud_pop), .pkt_load(pkt_load),
    .pkt_sel(pkt_sel), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int sel; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  int  m_cnt = 0;
  bit  m_acr = 1'b0, m_avi = 1'b0, m_aif = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pkt_load) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pkt_sel", int'(pkt_sel), e.sel);
          chk("load_cycle", cyc, e.cyc);
          chk("aud_pop", int'(aud_pop), (e.sel == 1) ? 1 : 0);
        end
      end else begin
        chk("aud_pop_idle", int'(aud_pop), 0);
      end
    end
  end

  // Reference priority model evaluated for a whole line at strobe time.
  task automatic model_line(input int t, input bit aud);
    int na = 0;
    if (m_cnt == 0) m_acr = 1'b1;
    m_cnt = (m_cnt + 1) % 45;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      if (m_acr)                  begin e.sel = 2; m_acr = 1'b0; end
      else if (AUD && aud && na < 2) begin e.sel = 1; na++; end
      else if (m_avi)             begin e.sel = 3; m_avi = 1'b0; end
      else if (m_aif)             begin e.sel = 4; m_aif = 1'b0; end
      else                              e.sel = 0;
      e.cyc = t + 2 + k * 32;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_line(input bit aud);
    int t;
    @(negedge clk);
    aud_avail   = aud;
    line_strobe = 1'b1;
    t = cyc;
    model_line(t, aud);
    @(negedge clk);
    line_strobe = 1'b0;
    chk("busy_start", int'(busy), 1);
    while (cyc < t + 97) @(negedge clk);
    chk("busy_last", int'(busy), 1);
    @(negedge clk);
    chk("busy_fall", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b1;
    m_avi = 1'b1;
    m_aif = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pkt_load", int'(pkt_load), 0);
    chk("rst_aud_pop", int'(aud_pop), 0);
    chk("rst_pkt_sel", int'(pkt_sel), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Line 0 carries ACR; following lines exercise audio and null fill.
    run_line(1'b0);
    run_line(1'b1);
    for (int i = 2; i <= 45; i++) run_line(i % 3 == 0);
    chk("line_cnt_wrap", int'(dut.r_line_cnt), m_cnt);

    vsync_pulse();
    run_line(1'b1);
    run_line(1'b1);
    run_line(1'b1);
    chk("q_drained_mid", exp_q.size(), 0);

    // Overlapping strobe, then reset mid-sequence.
    @(negedge clk);
    aud_avail   = 1'b0;
    line_strobe = 1'b1;
    t = cyc;
    model_line(t, 1'b0);
    @(negedge clk);
    line_strobe = 1'b0;
    while (cyc < t + 40) @(negedge clk);
    line_strobe = 1'b1;
    if (m_cnt == 0) m_acr = 1'b1;
    m_cnt = (m_cnt + 1) % 45;
    @(negedge clk);
    line_strobe = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    chk("busy_during_overrun", int'(busy), 1);
    chk("line_cnt_overrun", int'(dut.r_line_cnt), m_cnt);
    while (cyc < t + 50) @(negedge clk);
    rst         = 1'b1;
    line_strobe = 1'b1;
    exp_q.delete();
    m_cnt = 0; m_acr = 1'b0; m_avi = 1'b0; m_aif = 1'b0;
    @(negedge clk);
    rst         = 1'b0;
    line_strobe = 1'b0;
    chk("overrun_cleared", int'(overrun), 0);
    chk("busy_after_rst", int'(busy), 0);
    repeat (100) @(negedge clk);
    chk("idle_after_rst", int'(busy), 0);
    chk("line_cnt_after_rst", int'(dut.r_line_cnt), 0);

    run_line(1'b1);
    run_line(1'b1);
    chk("q_drained_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
